// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller: one shared decoder, common-anode digit bus,
// double-buffered word with frame-aligned commit. Optional macro: LEADING_ZERO_BLANK_EN.
module seven_seg_scan_ctrl #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned DWELL_CYCLES = 50000,
  parameter int unsigned BLANK_CYCLES = 500,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load_valid,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  output logic                    load_ready,
  output logic [3:0]              dec_val,
  output logic                    dec_blank,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    frame_tick
);

  localparam int unsigned IdxW  = $clog2(NUM_DIGITS);
  localparam int unsigned WordW = 4 * NUM_DIGITS;

  typedef enum logic [0:0] {StBlank, StDrive} state_e;

  state_e                  state_q, state_d;
  logic [IdxW-1:0]         idx_q, idx_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [WordW-1:0]        active_q, active_d;
  logic [WordW-1:0]        pend_q, pend_d;
  logic                    pend_full_q, pend_full_d;
  logic                    frame_end, accept;
  logic                    tick_d, blank_d;
  logic [3:0]              val_d;
  logic [NUM_DIGITS-1:0]   an_n_d;
`ifdef LEADING_ZERO_BLANK_EN
  logic                    lz;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q + CNT_W'(1);
    unique case (state_q)
      StBlank: begin
        if (cnt_q == CNT_W'(BLANK_CYCLES - 1)) begin
          state_d = StDrive;
          cnt_d   = '0;
        end
      end
      StDrive: begin
        if (cnt_q == CNT_W'(DWELL_CYCLES - 1)) begin
          state_d = StBlank;
          cnt_d   = '0;
          idx_d   = (idx_q == IdxW'(NUM_DIGITS - 1)) ? '0 : idx_q + IdxW'(1);
        end
      end
    endcase

    frame_end = (state_q == StDrive) && (idx_q == IdxW'(NUM_DIGITS - 1)) &&
                (cnt_q == CNT_W'(DWELL_CYCLES - 1));
    accept    = load_valid && load_ready;

    // Commit only at frame end so a frame never mixes two words.
    active_d    = active_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    if (frame_end && pend_full_q) begin
      active_d    = pend_q;
      pend_full_d = 1'b0;
    end else if (accept && frame_end) begin
      active_d = load_data;
    end else if (accept) begin
      pend_d      = load_data;
      pend_full_d = 1'b1;
    end

    // Outputs are registered from the next state so they line up with state_q.
    an_n_d = '1;
    if (state_d == StDrive) an_n_d[idx_d] = 1'b0;
    val_d   = active_d[32'(idx_d) * 4 +: 4];
    blank_d = (state_d == StBlank);
`ifdef LEADING_ZERO_BLANK_EN
    lz = (idx_d != '0);
    for (int k = 0; k < int'(NUM_DIGITS); k++) begin
      if (k >= int'(idx_d) && active_d[4 * k +: 4] != 4'h0) lz = 1'b0;
    end
    if (lz) blank_d = 1'b1;
`endif
    tick_d = (state_d == StDrive) && (idx_d == IdxW'(NUM_DIGITS - 1)) &&
             (cnt_d == CNT_W'(DWELL_CYCLES - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StBlank;
      idx_q       <= '0;
      cnt_q       <= '0;
      active_q    <= '0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      load_ready  <= 1'b1;
      an_n        <= '1;
      dec_val     <= '0;
      dec_blank   <= 1'b1;
      frame_tick  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      active_q    <= active_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      load_ready  <= ~pend_full_d;
      an_n        <= an_n_d;
      dec_val     <= val_d;
      dec_blank   <= blank_d;
      frame_tick  <= tick_d;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed bench for seven_seg_scan_ctrl with NUM_DIGITS=4, DWELL_CYCLES=4, BLANK_CYCLES=2.
module tb_seven_seg_scan_ctrl;

  localparam int Frame  = 24;
  localparam int Phase  = 6;
  localparam int BlankC = 2;
`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LzEn = 1'b1;
`else
  localparam bit LzEn = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        load_valid;
  logic [15:0] load_data;
  logic        load_ready;
  logic [3:0]  dec_val;
  logic        dec_blank;
  logic [3:0]  an_n;
  logic        frame_tick;

  int errors;
  int checks;

  logic        v_tab [0:71];
  logic [15:0] d_tab [0:71];
  logic        r_exp [0:71];
  logic [15:0] fw    [0:2];

  seven_seg_scan_ctrl #(
    .NUM_DIGITS  (4),
    .DWELL_CYCLES(4),
    .BLANK_CYCLES(2),
    .CNT_W       (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .load_valid(load_valid),
    .load_data (load_data),
    .load_ready(load_ready),
    .dec_val   (dec_val),
    .dec_blank (dec_blank),
    .an_n      (an_n),
    .frame_tick(frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic lz_blank(input logic [15:0] w, input int d);
    return LzEn && (d > 0) && ((w >> (4 * d)) == 16'h0);
  endfunction

  task automatic clear_tabs();
    for (int i = 0; i < 72; i++) begin
      v_tab[i] = 1'b0;
      d_tab[i] = 16'h0;
      r_exp[i] = 1'b1;
    end
    for (int i = 0; i < 3; i++) fw[i] = 16'h0;
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    load_valid = 1'b0;
    load_data  = 16'h0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Called at the start of cycle 0 (just after the last reset edge).
  task automatic run(input int ncyc, input string name);
    for (int t = 0; t < ncyc; t++) begin
      int          p;
      int          d;
      logic        drive;
      logic [15:0] w;
      logic [3:0]  exp_an;
      load_valid = v_tab[t];
      load_data  = d_tab[t];
      p      = t % Frame;
      d      = p / Phase;
      drive  = (p % Phase) >= BlankC;
      w      = fw[t / Frame];
      exp_an = 4'hF;
      if (drive) exp_an[d] = 1'b0;
      @(negedge clk);
      check_eq($sformatf("%s t=%0d an_n", name, t), 32'(an_n), 32'(exp_an));
      check_eq($sformatf("%s t=%0d frame_tick", name, t), 32'(frame_tick), 32'(p == Frame - 1));
      check_eq($sformatf("%s t=%0d dec_val", name, t), 32'(dec_val), 32'(w[4 * d +: 4]));
      check_eq($sformatf("%s t=%0d dec_blank", name, t), 32'(dec_blank),
               32'(drive ? lz_blank(w, d) : 1'b1));
      check_eq($sformatf("%s t=%0d load_ready", name, t), 32'(load_ready), 32'(r_exp[t]));
      @(posedge clk);
      #1;
    end
    load_valid = 1'b0;
  endtask

  initial begin
    errors     = 0;
    checks     = 0;
    reset      = 1'b1;
    load_valid = 1'b0;
    load_data  = 16'h0;

    // Free-running scan from reset.
    clear_tabs();
    do_reset();
    run(60, "scan");

    // Single load mid-frame commits at frame end.
    clear_tabs();
    v_tab[5] = 1'b1;
    d_tab[5] = 16'hA3F7;
    for (int t = 6; t <= 23; t++) r_exp[t] = 1'b0;
    fw[1] = 16'hA3F7;
    fw[2] = 16'hA3F7;
    do_reset();
    run(72, "load");

    // Back-to-back words: second one stalls until the first commits.
    clear_tabs();
    v_tab[2] = 1'b1;
    d_tab[2] = 16'h1234;
    for (int t = 3; t <= 24; t++) begin
      v_tab[t] = 1'b1;
      d_tab[t] = 16'h5678;
    end
    for (int t = 3; t <= 23; t++) r_exp[t] = 1'b0;
    for (int t = 25; t <= 47; t++) r_exp[t] = 1'b0;
    fw[1] = 16'h1234;
    fw[2] = 16'h5678;
    do_reset();
    run(72, "stall");

    // Accept on the frame-end cycle goes straight to the active word.
    clear_tabs();
    v_tab[23] = 1'b1;
    d_tab[23] = 16'hBEEF;
    fw[1] = 16'hBEEF;
    fw[2] = 16'hBEEF;
    do_reset();
    run(48, "direct");

    // Reset in DRIVE of digit 2 with a word pending discards it.
    clear_tabs();
    v_tab[1] = 1'b1;
    d_tab[1] = 16'hC0DE;
    for (int t = 2; t < 16; t++) r_exp[t] = 1'b0;
    do_reset();
    run(16, "prerst");
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    clear_tabs();
    run(48, "postrst");

    // Leading-zero word.
    clear_tabs();
    v_tab[0] = 1'b1;
    d_tab[0] = 16'h0050;
    for (int t = 1; t <= 23; t++) r_exp[t] = 1'b0;
    fw[1] = 16'h0050;
    fw[2] = 16'h0050;
    do_reset();
    run(48, "lzero");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
